noc_local_inject_arbiter: RTL and testbench

Packet-level round-robin arbiter that shares the router's local (P) injection port among `NReq` tile-side flit sources. It sits between the tile's NoC queues and the local input of the router wrapper (`data_p_in`, `data_void_in[4]`, `stop_out[4]`). It registers the selected flit stream through one output stage and locks the grant from head flit to tail flit, so packets never interleave.

---
 rtl/noc_local_inject_arbiter.sv | 86 ++++++++
 tb/tb_noc_local_inject_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/noc_local_inject_arbiter.sv
// noc_local_inject_arbiter: packet-level round-robin arbiter for the router's local injection port,
// with one registered output stage and a head-to-tail grant lock.
module noc_local_inject_arbiter #(
    parameter int NReq  = 4,
    parameter int Width = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NReq*Width-1:0] req_data_in,
    input  logic [NReq-1:0]       req_void_in,
    output logic [NReq-1:0]       req_stop_out,
    output logic [Width-1:0]      data_p_out,
    output logic                  data_void_p_out,
    input  logic                  stop_p_in,
    output logic [NReq-1:0]       grant_out,
    output logic                  err_out
);
    localparam int IW = $clog2(NReq);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_LOCK = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [IW-1:0]    owner_q, owner_d, rr_ptr_q, rr_ptr_d, sel, cur;
    logic             valid_q, valid_d, err_q, err_d;
    logic [Width-1:0] data_q, data_d, cur_flit;
    logic [NReq-1:0]  cand, bad, cur_oh;
    logic             found, lock, can_accept, acc;

    always_comb begin
        for (int i = 0; i < NReq; i++) begin
            cand[i] = ~req_void_in[i] & req_data_in[i*Width+Width-1];
            bad[i]  = ~req_void_in[i] & ~req_data_in[i*Width+Width-1];
        end
    end

    // first head-carrying requester at or after rr_ptr, wrapping
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int k = 0; k < NReq; k++) begin
            if (!found && cand[(int'(rr_ptr_q) + k) % NReq]) begin
                found = 1'b1;
                sel   = IW'((int'(rr_ptr_q) + k) % NReq);
            end
        end
    end

    always_comb begin
        lock         = state_q == S_LOCK;
        cur          = lock ? owner_q : sel;
        cur_flit     = req_data_in[int'(cur)*Width +: Width];
        cur_oh       = NReq'(1) << cur;
        can_accept   = ~valid_q | ~stop_p_in;
        acc          = can_accept & (lock ? ~req_void_in[cur] : found);
        req_stop_out = ~(cur_oh & {NReq{can_accept & (lock | found)}});
        grant_out    = (lock | acc) ? cur_oh : '0;
        valid_d      = acc | (valid_q & stop_p_in);
        data_d       = acc ? cur_flit : data_q;
        err_d        = err_q | (~lock & (|bad));
        state_d      = acc ? (cur_flit[Width-2] ? S_IDLE : S_LOCK) : state_q;
        owner_d      = acc ? cur : owner_q;
        rr_ptr_d     = (acc & cur_flit[Width-2]) ? IW'((int'(cur) + 1) % NReq) : rr_ptr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            err_q    <= err_d;
        end
    end

    assign data_p_out      = data_q;
    assign data_void_p_out = ~valid_q;
    assign err_out         = err_q;
endmodule

// File: tb/tb_noc_local_inject_arbiter.sv
// tb_noc_local_inject_arbiter: randomized and directed bench with a packet-level reference model
// and an output scoreboard drained by an independent monitor.
module tb_noc_local_inject_arbiter;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] req_data_in = '0;
    logic [3:0]   req_void_in = '1;
    logic [3:0]   req_stop_out, grant_out;
    logic [31:0]  data_p_out;
    logic         data_void_p_out, err_out;
    logic         stop_p_in = 1'b0;

    noc_local_inject_arbiter #(.NReq(4), .Width(32)) dut (
        .clk(clk), .rst(rst), .req_data_in(req_data_in), .req_void_in(req_void_in),
        .req_stop_out(req_stop_out), .data_p_out(data_p_out), .data_void_p_out(data_void_p_out),
        .stop_p_in(stop_p_in), .grant_out(grant_out), .err_out(err_out)
    );

    always #5 clk = ~clk;

    int          checks = 0, errors = 0, seq = 0, stop_pct = 0;
    int          prob[4];
    logic [31:0] src_q[4][$];
    logic [31:0] sb[$];
    int          m_owner = -1, m_rr = 0;
    bit          m_valid = 1'b0, m_err = 1'b0;
    logic [31:0] m_data = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // packet flit: {head, tail, 6'b0, requester id, sequence}
    task automatic gen(input int i, input int len);
        for (int f = 0; f < len; f++) begin
            src_q[i].push_back({1'(f == 0), 1'(f == len - 1), 6'd0, 8'(i), 16'(seq)});
            seq++;
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_stop", 32'(req_stop_out), 32'hf);
        chk("rst_void", 32'(data_void_p_out), 32'd1);
        chk("rst_data", data_p_out, 32'd0);
        chk("rst_grant", 32'(grant_out), 32'd0);
        chk("rst_err", 32'(err_out), 32'd0);
    endtask

    // one clock: drive after the edge, predict and compare at the falling edge, advance the model
    task automatic cycle();
        logic [3:0] es, eg;
        bit         can, acc;
        int         sel, who;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (src_q[i].size() > 0 && $urandom_range(99) < prob[i]) begin
                req_void_in[i] = 1'b0;
                req_data_in[i*32 +: 32] = src_q[i][0];
            end else begin
                req_void_in[i] = 1'b1;
                req_data_in[i*32 +: 32] = $urandom();
            end
        end
        stop_p_in = $urandom_range(99) < stop_pct;
        @(negedge clk);
        can = !m_valid || !stop_p_in;
        sel = -1;
        if (m_owner < 0)
            for (int k = 0; k < 4; k++)
                if (sel < 0 && !req_void_in[(m_rr + k) % 4] && req_data_in[((m_rr + k) % 4)*32 + 31])
                    sel = (m_rr + k) % 4;
        es = 4'hf;
        eg = 4'h0;
        if (m_owner >= 0) begin
            es[m_owner] = !can;
            eg[m_owner] = 1'b1;
        end else if (sel >= 0 && can) begin
            es[sel] = 1'b0;
            eg[sel] = 1'b1;
        end
        chk("stop", 32'(req_stop_out), 32'(es));
        chk("grant", 32'(grant_out), 32'(eg));
        chk("void", 32'(data_void_p_out), 32'(!m_valid));
        chk("err", 32'(err_out), 32'(m_err));
        if (m_valid) chk("hold_data", data_p_out, m_data);
        acc = 1'b0;
        who = 0;
        for (int i = 0; i < 4; i++)
            if (!req_void_in[i] && !es[i]) begin
                acc = 1'b1;
                who = i;
            end
        if (m_owner < 0)
            for (int i = 0; i < 4; i++)
                if (!req_void_in[i] && !req_data_in[i*32 + 31]) m_err = 1'b1;
        if (acc) begin
            m_data = src_q[who].pop_front();
            sb.push_back(m_data);
            if (m_data[30]) begin
                m_rr = (who + 1) % 4;
                m_owner = -1;
            end else m_owner = who;
        end
        m_valid = acc || (m_valid && stop_p_in);
    endtask

    task automatic reset_mid();
        #2 rst = 1'b1;
        #1 check_reset_outputs();
        m_owner = -1;
        m_rr = 0;
        m_valid = 1'b0;
        m_err = 1'b0;
        sb.delete();
        req_void_in = '1;
        for (int i = 0; i < 4; i++)
            while (src_q[i].size() > 0 && !src_q[i][0][31]) void'(src_q[i].pop_front());
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        stop_pct = 0;
        prob = '{100, 100, 100, 100};
        while ((sb.size() > 0 || src_q[0].size() + src_q[1].size() + src_q[2].size() + src_q[3].size() > 0) && n < 300) begin
            cycle();
            n++;
        end
        chk("drain_sb_empty", 32'(sb.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        if (!rst && data_void_p_out === 1'b0 && stop_p_in === 1'b0) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out_unexpected: got %h expected no flit at %0t", data_p_out, $time);
            end else chk("out_flit", data_p_out, sb.pop_front());
        end
    end

    initial begin
        prob = '{0, 0, 0, 0};
        #1 check_reset_outputs();
        @(posedge clk);
        #1 rst = 1'b0;
        // single requester three-flit packet
        src_q[0].push_back(32'h8000_0001);
        src_q[0].push_back(32'h0000_0002);
        src_q[0].push_back(32'h4000_0003);
        prob = '{100, 0, 0, 0};
        repeat (6) cycle();
        // fairness with single-flit packets from everyone
        for (int r = 0; r < 5; r++) for (int i = 0; i < 4; i++) gen(i, 1);
        prob = '{100, 100, 100, 100};
        repeat (24) cycle();
        // lock: req1 long packet, req0 head arrives one cycle later
        gen(1, 4);
        gen(0, 1);
        prob = '{0, 100, 0, 0};
        cycle();
        prob[0] = 100;
        repeat (8) cycle();
        // backpressure mid-packet
        gen(2, 6);
        prob = '{0, 0, 100, 0};
        repeat (2) cycle();
        stop_pct = 100;
        repeat (5) cycle();
        stop_pct = 0;
        repeat (8) cycle();
        // randomized traffic
        stop_pct = 30;
        for (int c = 0; c < 1500; c++) begin
            if (c % 100 == 0) for (int i = 0; i < 4; i++) prob[i] = $urandom_range(100);
            for (int i = 0; i < 4; i++)
                if (src_q[i].size() < 3 && $urandom_range(9) == 0) gen(i, $urandom_range(1, 4));
            cycle();
        end
        drain();
        // protocol error: body flit from req2 while idle, req3 keeps flowing
        src_q[2].push_front(32'h0000_0bad);
        gen(3, 2);
        gen(3, 1);
        prob = '{0, 0, 100, 100};
        repeat (8) cycle();
        chk("err_sticky", 32'(err_out), 32'd1);
        chk("err_req2_stopped", 32'(req_stop_out[2]), 32'd1);
        chk("err_req3_done", 32'(src_q[3].size()), 32'd0);
        // reset after two flits of a four-flit packet
        gen(0, 4);
        gen(1, 1);
        gen(2, 1);
        gen(3, 1);
        prob = '{100, 0, 0, 0};
        for (int n = 0; n < 20 && src_q[0].size() > 2; n++) cycle();
        chk("pre_reset_accepted", 32'(src_q[0].size()), 32'd2);
        reset_mid();
        prob = '{100, 100, 100, 100};
        repeat (10) cycle();
        drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
